// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux: round-robin or fixed-select arbitration with packet locking.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 beat/cycle when out_ready is held high.
// Backpressure: in_ready is asserted only for the granted channel while the output register can load.
module stream_mux_rr #(
    parameter int inputSize = 32,
    parameter int channels  = 4,
    parameter int addrBits  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [channels*inputSize-1:0] in_data,
    input  logic [channels-1:0]           in_valid,
    input  logic [channels-1:0]           in_last,
    output logic [channels-1:0]           in_ready,
    input  logic                          mode,
    input  logic [addrBits-1:0]           addr,
    output logic [inputSize-1:0]          out,
    output logic                          out_last,
    output logic [addrBits-1:0]           out_chan,
    output logic                          out_valid,
    input  logic                          out_ready
);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t             r_state;
    lock_state_t             w_state_nxt;
    logic                    w_lock;
    logic [addrBits-1:0]     r_lock_chan;
    logic [addrBits-1:0]     r_ptr;
    logic [inputSize-1:0]    r_out;
    logic                    r_out_last;
    logic [addrBits-1:0]     r_out_chan;
    logic                    r_out_valid;

    logic                    w_load;
    logic [channels-1:0]     w_grant;
    logic [addrBits-1:0]     w_gnt_idx;
    logic                    w_gnt_any;
    logic                    w_xfer;
    logic [inputSize-1:0]    w_sel_data;
    logic                    w_sel_last;
    logic [addrBits-1:0]     w_ptr_nxt;

    // Output register may take a new beat when empty or being drained this cycle.
    assign w_load    = !r_out_valid || out_ready;
    assign w_xfer    = w_gnt_any && w_load && !reset;
    assign in_ready  = (w_load && !reset) ? w_grant : '0;
    assign w_ptr_nxt = (w_gnt_idx == addrBits'(channels - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign out       = r_out;
    assign out_last  = r_out_last;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

    // Grant: locked channel wins outright, else fixed select, else first valid from the pointer.
    always_comb begin
        w_grant   = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        if (w_lock) begin
            for (int i = 0; i < channels; i++) begin
                if (addrBits'(i) == r_lock_chan && in_valid[i]) begin
                    w_grant[i] = 1'b1;
                    w_gnt_idx  = addrBits'(i);
                    w_gnt_any  = 1'b1;
                end
            end
        end else if (mode) begin
            // Out-of-range addr never matches a channel, so it yields no grant.
            for (int i = 0; i < channels; i++) begin
                if (addrBits'(i) == addr && in_valid[i]) begin
                    w_grant[i] = 1'b1;
                    w_gnt_idx  = addrBits'(i);
                    w_gnt_any  = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < channels; k++) begin
                for (int i = 0; i < channels; i++) begin
                    // Candidate at scan offset k is (ptr + k) mod channels.
                    if (!w_gnt_any && in_valid[i] &&
                        ((int'(r_ptr) + k == i) || (int'(r_ptr) + k == i + channels))) begin
                        w_grant[i] = 1'b1;
                        w_gnt_idx  = addrBits'(i);
                        w_gnt_any  = 1'b1;
                    end
                end
            end
        end
    end

    // Route the granted channel's data and last flag toward the output register.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < channels; i++) begin
            if (w_grant[i]) begin
                w_sel_data = in_data[i*inputSize +: inputSize];
                w_sel_last = in_last[i];
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= UNLOCKED;
        else       r_state <= w_state_nxt;
    end

    // Lock next state: lock on a non-last beat, release on the locked packet's last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UNLOCKED: if (w_xfer && !w_sel_last) w_state_nxt = LOCKED;
            LOCKED:   if (w_xfer &&  w_sel_last) w_state_nxt = UNLOCKED;
            default:  w_state_nxt = UNLOCKED;
        endcase
    end

    // Lock state decode.
    always_comb begin
        w_lock = (r_state == LOCKED);
    end

    // Locked channel and round-robin pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_chan <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            if (!w_lock && !w_sel_last) r_lock_chan <= w_gnt_idx;
            if (w_sel_last)             r_ptr       <= w_ptr_nxt;
        end
    end

    // Output register: load on transfer, empty on idle load, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out       <= w_sel_data;
                r_out_last  <= w_sel_last;
                r_out_chan  <= w_gnt_idx;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance checked against a packet-level model.
// Directed scenarios (round-robin, fixed select, lock, backpressure, reset) precede random traffic.
// Inputs change on the falling edge; in_ready and registered outputs are sampled away from the rising edge.
module tb_stream_mux_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Per-instance stimulus: index 0 drives the 4-channel DUT, index 1 the 3-channel DUT.
    logic [31:0] v_data  [2][4];
    logic [3:0]  v_valid [2];
    logic [3:0]  v_last  [2];
    logic        v_mode  [2];
    logic [1:0]  v_addr  [2];
    logic        v_ordy  [2];

    logic [127:0] d4_data;
    logic [95:0]  d3_data;
    logic [3:0]   d4_ready;
    logic [2:0]   d3_ready;
    logic [31:0]  d4_out, d3_out;
    logic         d4_last, d3_last, d4_ov, d3_ov;
    logic [1:0]   d4_chan, d3_chan;

    always_comb begin
        for (int i = 0; i < 4; i++) d4_data[i*32 +: 32] = v_data[0][i];
        for (int i = 0; i < 3; i++) d3_data[i*32 +: 32] = v_data[1][i];
    end

    stream_mux_rr #(.inputSize(32), .channels(4), .addrBits(2)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(d4_data), .in_valid(v_valid[0]),
        .in_last(v_last[0]), .in_ready(d4_ready), .mode(v_mode[0]), .addr(v_addr[0]),
        .out(d4_out), .out_last(d4_last), .out_chan(d4_chan), .out_valid(d4_ov),
        .out_ready(v_ordy[0])
    );

    stream_mux_rr #(.inputSize(32), .channels(3), .addrBits(2)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(d3_data), .in_valid(v_valid[1][2:0]),
        .in_last(v_last[1][2:0]), .in_ready(d3_ready), .mode(v_mode[1]), .addr(v_addr[1]),
        .out(d3_out), .out_last(d3_last), .out_chan(d3_chan), .out_valid(d3_ov),
        .out_ready(v_ordy[1])
    );

    // Reference model state, one entry per instance.
    logic [31:0] m_out  [2];
    bit          m_last [2];
    int          m_chan [2];
    bit          m_vld  [2];
    int          m_ptr  [2];
    bit          m_lock [2];
    int          m_lchan[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic int nch(input int id);
        return (id == 0) ? 4 : 3;
    endfunction

    // Which channel the arbitration rules pick this cycle, or -1 for none.
    function automatic int model_grant(input int id);
        int n = nch(id);
        if (m_lock[id]) return v_valid[id][m_lchan[id]] ? m_lchan[id] : -1;
        if (v_mode[id]) begin
            if (int'(v_addr[id]) < n && v_valid[id][v_addr[id]]) return int'(v_addr[id]);
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c = (m_ptr[id] + k) % n;
            if (v_valid[id][c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int id = 0; id < 2; id++) begin
            m_out[id] = '0; m_last[id] = 0; m_chan[id] = 0; m_vld[id] = 0;
            m_ptr[id] = 0;  m_lock[id] = 0; m_lchan[id] = 0;
        end
    endtask

    // One clock: check in_ready for the current inputs, advance the model, check registered outputs.
    task automatic step();
        #1;
        for (int id = 0; id < 2; id++) begin
            logic [3:0] got_rdy = (id == 0) ? d4_ready : {1'b0, d3_ready};
            logic [3:0] exp_rdy = '0;
            bit ld = !m_vld[id] || v_ordy[id];
            int g  = model_grant(id);
            if (!reset && ld && g >= 0) exp_rdy[g] = 1'b1;
            chk($sformatf("in_ready[n=%0d]", nch(id)), 64'(got_rdy), 64'(exp_rdy));
            if (!reset && ld) begin
                if (g >= 0) begin
                    bit lst = v_last[id][g];
                    m_out[id] = v_data[id][g]; m_last[id] = lst; m_chan[id] = g; m_vld[id] = 1;
                    if (!m_lock[id] && !lst) begin m_lock[id] = 1; m_lchan[id] = g; end
                    else if (m_lock[id] && lst) m_lock[id] = 0;
                    if (lst) m_ptr[id] = (g + 1) % nch(id);
                end else begin
                    m_vld[id] = 0;
                end
            end
        end
        if (reset) model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("out_valid[n=4]", 64'(d4_ov),   64'(m_vld[0]));
        chk("out[n=4]",       64'(d4_out),  64'(m_out[0]));
        chk("out_last[n=4]",  64'(d4_last), 64'(m_last[0]));
        chk("out_chan[n=4]",  64'(d4_chan), 64'(m_chan[0]));
        chk("out_valid[n=3]", 64'(d3_ov),   64'(m_vld[1]));
        chk("out[n=3]",       64'(d3_out),  64'(m_out[1]));
        chk("out_last[n=3]",  64'(d3_last), 64'(m_last[1]));
        chk("out_chan[n=3]",  64'(d3_chan), 64'(m_chan[1]));
    endtask

    // Same directed pattern on both instances; data tags identify instance and channel.
    task automatic set_all(input logic [3:0] vld, input logic [3:0] lst, input logic md,
                           input logic [1:0] ad, input logic ordy);
        for (int id = 0; id < 2; id++) begin
            v_valid[id] = vld; v_last[id] = lst; v_mode[id] = md;
            v_addr[id]  = ad;  v_ordy[id] = ordy;
            for (int c = 0; c < 4; c++) v_data[id][c] = 32'hA5A5_0000 | 32'(id * 16 + c);
        end
    endtask

    task automatic randomize_inputs();
        reset = ($urandom_range(0, 149) == 0);
        for (int id = 0; id < 2; id++) begin
            for (int c = 0; c < 4; c++) begin
                v_valid[id][c] = ($urandom_range(0, 3) != 0);
                v_last[id][c]  = ($urandom_range(0, 1) == 0);
                v_data[id][c]  = $urandom;
            end
            if ($urandom_range(0, 19) == 0) v_mode[id] = ~v_mode[id];
            v_addr[id] = 2'($urandom_range(0, 3));
            v_ordy[id] = ($urandom_range(0, 9) < 7);
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        set_all(4'h0, 4'h0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // Round-robin fairness with single-beat packets on every channel.
        set_all(4'hF, 4'hF, 1'b0, 2'd0, 1'b1);
        repeat (9) step();

        // Fixed select: addr=2 on both, then addr=3 (out of range for the 3-channel DUT).
        set_all(4'hF, 4'hF, 1'b1, 2'd2, 1'b1);
        repeat (3) step();
        set_all(4'hF, 4'hF, 1'b1, 2'd3, 1'b1);
        repeat (3) step();

        // Backpressure then release.
        set_all(4'hF, 4'hF, 1'b0, 2'd0, 1'b0);
        repeat (4) step();
        set_all(4'hF, 4'hF, 1'b0, 2'd0, 1'b1);
        repeat (2) step();

        // Packet lock: ch1 sends three beats while ch0 stays valid; mode/addr flip mid-packet.
        reset = 1'b1; step(); reset = 1'b0;
        set_all(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1); step();
        set_all(4'b0011, 4'b0000, 1'b1, 2'd0, 1'b1); step();
        set_all(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1); step();
        set_all(4'b0011, 4'b0010, 1'b0, 2'd0, 1'b1); step();
        set_all(4'b1101, 4'b1111, 1'b0, 2'd0, 1'b1); step();
        set_all(4'b0001, 4'b1111, 1'b0, 2'd0, 1'b1); step();

        // Reset mid-packet on ch2, then ch0 should win from a cleared pointer.
        set_all(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1); step();
        reset = 1'b1; step(); reset = 1'b0;
        set_all(4'b0101, 4'b1111, 1'b0, 2'd0, 1'b1);
        repeat (3) step();

        // Random traffic.
        repeat (4000) begin
            randomize_inputs();
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit registered mux with valid/ready handshakes on every input and on the output.
- Chooses the source channel either by round-robin arbitration or by a fixed select (addr).
- Supports multi-beat packets: once a packet starts, the grant stays locked on that channel until its last beat.
- Sits between pipeline producers and a shared consumer (e.g. writeback or memory-request path) wherever the combinational 2:1/3:1 muxes cannot be used because sources stall.

Parameters:
- inputSize, 32: data width W per channel.
- channels, 4: number of input channels N, 2..16.
- addrBits, 2: width of addr, ceil(log2(channels)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  channels*inputSize  channel i occupies bits [i*inputSize +: inputSize].
- in_valid  input  channels  per-channel beat valid.
- in_last  input  channels  per-channel last beat of packet.
- in_ready  output  channels  per-channel beat accepted this cycle.
- mode  input  1  0 = round-robin, 1 = fixed select by addr.
- addr  input  addrBits  channel select when mode=1.
- out  output  inputSize  registered data.
- out_last  output  1  registered last flag.
- out_chan  output  addrBits  channel index of the beat in out.
- out_valid  output  1  out holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset values (cycle after reset=1):
  - out = 0, out_last = 0, out_chan = 0, out_valid = 0.
  - rr pointer = 0, lock = 0, lock_chan = 0.
  - in_ready = 0 while reset is high.
- load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant selection (combinational, one-hot or zero):
  - lock=1: grant = lock_chan, if in_valid[lock_chan]. Mode and addr are ignored.
  - lock=0, mode=1: grant = addr, if addr < channels and in_valid[addr]. If addr >= channels, there is no grant.
  - lock=0, mode=0: grant = the first valid channel scanning pointer, pointer+1, ..., wrapping modulo channels.
- in_ready[i] = load && grant[i] && !reset.
- Transfer on channel i: in_valid[i] && in_ready[i].
  - Next edge: out <= in_data slice i, out_last <= in_last[i], out_chan <= i, out_valid <= 1.
- On load=1 with no transfer: out_valid <= 0; out, out_last and out_chan hold their values.
- On load=0: all output registers hold. out must stay stable while out_valid && !out_ready.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready is held at 1.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED on a transfer with in_last=0. lock_chan <= granted channel.
  - LOCKED -> UNLOCKED on a transfer from lock_chan with in_last=1.
  - A transfer with in_last=1 while UNLOCKED (single-beat packet) stays UNLOCKED.
- Pointer: on a transfer with in_last=1, pointer <= (granted + 1) mod channels. This applies in both modes. No other event changes the pointer.
- Boundary conditions:
  - Pointer wrap: pointer = channels-1 wraps to 0. This holds for non-power-of-two channel counts.
  - Locked channel deasserts valid mid-packet: no grant and no transfer. The lock holds and other channels are blocked.
  - mode or addr changes while LOCKED: no effect until the packet's last beat.
  - Simultaneous out_ready and new transfer: the old beat is consumed and the new beat is registered in the same edge, with no bubble.
  - Reset mid-packet: lock is dropped, out_valid <= 0, and the in-flight beat is discarded.

Test Plan:
- Round-robin fairness: channels=4, mode=0, out_ready=1, all in_valid=1, in_last=1 -> out_chan sequence 0,1,2,3,0,... with out_valid=1 every cycle from cycle 1.
- Fixed select: mode=1, addr=2, all channels valid, in_data ch2=32'hA5A5_0002 -> only in_ready[2]=1; next cycle out=32'hA5A5_0002, out_chan=2. addr=3 with channels=3 -> in_ready=0, out_valid=0.
- Packet lock: ch1 sends 3 beats (in_last=0,0,1) while ch0 stays valid -> ch0 is blocked until ch1's last beat registers. Next grant goes to ch2 if valid, else ch3, else ch0 (pointer=2).
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out, out_chan and out_last are stable and in_ready=0. out_ready=1 -> the next beat follows the very next cycle.
- Reset mid-packet: ch2 locked after beat 1, reset=1 for 1 cycle -> out_valid=0, pointer=0, lock cleared. Next arbitration grants ch0 if valid.
- Non-power-of-two: channels=3, addrBits=2, last grant ch2 -> pointer wraps to 0. Only ch0..ch2 are ever granted.
